mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 165 ++++++++++++++++
 tb/tb_mdu.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// rtl/mdu.sv - iterative multiply/divide unit with HI/LO result registers
//
// One 32-cycle iteration engine shared by multiply (shift-add) and divide
// (restoring shift-subtract). Signed operations run on magnitudes and fix
// the sign when the result is written back.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      operation request, sampled on the rising edge
//   op[2:0]    000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   rs1, rt1   operands from the GPR rs/rt read ports
//   busy       high while an iterative operation runs
//   done       one-cycle pulse after hi/lo take a new MULT/DIV result
//   hi, lo     HI/LO registers
//
// Build option: define MDU_DIV_EN to include DIV/DIVU; otherwise 010/011 are no-ops.

module mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rt1,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [31:0] d_q;        // multiplicand (mult) or divisor (div) magnitude
  logic [63:0] work;       // {acc, multiplier} or {remainder, dividend/quotient}
  logic [63:0] work_nx;
  logic        neg_q;      // negate product / quotient at write-back

  logic        op_mul, op_div, accept, sgn, rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_nx, prod;

`ifdef MDU_DIV_EN
  logic        is_div, neg_r, dz;
  logic [31:0] a_q;        // raw dividend, returned as HI on divide by zero
  logic [32:0] trial;
  logic        ge;
  logic [31:0] rem_nx, quo, rem;
  logic [63:0] div_nx;
`endif

  assign op_mul = (op[2:1] == 2'b00);
`ifdef MDU_DIV_EN
  assign op_div = (op[2:1] == 2'b01);
`else
  assign op_div = 1'b0;
`endif

  assign sgn    = ~op[0];
  assign rs_neg = sgn & rs1[31];
  assign rt_neg = sgn & rt1[31];
  assign rs_mag = rs_neg ? (32'd0 - rs1) : rs1;
  assign rt_mag = rt_neg ? (32'd0 - rt1) : rt1;
  assign accept = (state == IDLE) & start & (op_mul | op_div);
  assign busy   = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (cnt == 5'd31) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole pair right by one.
    mul_sum = {1'b0, work[63:32]} + {1'b0, (work[0] ? d_q : 32'd0)};
    mul_nx  = {mul_sum, work[31:1]};
    prod    = neg_q ? (64'd0 - mul_nx) : mul_nx;
    work_nx = mul_nx;
`ifdef MDU_DIV_EN
    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract only when it fits; the quotient bit fills the vacated LSB.
    trial   = {work[63:32], work[31]};
    ge      = (trial >= {1'b0, d_q});
    rem_nx  = ge ? (trial[31:0] - d_q) : trial[31:0];
    div_nx  = {rem_nx, work[30:0], ge};
    quo     = neg_q ? (32'd0 - div_nx[31:0])  : div_nx[31:0];
    rem     = neg_r ? (32'd0 - div_nx[63:32]) : div_nx[63:32];
    if (is_div) work_nx = div_nx;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= 5'd0;
      d_q   <= 32'd0;
      work  <= 64'd0;
      neg_q <= 1'b0;
      done  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
`ifdef MDU_DIV_EN
      is_div <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      a_q    <= 32'd0;
`endif
    end else begin
      done <= (state == RUN) && (cnt == 5'd31);
      if (accept) begin
        cnt   <= 5'd0;
        neg_q <= rs_neg ^ rt_neg;
        if (op_div) begin
          d_q  <= rt_mag;
          work <= {32'd0, rs_mag};
        end else begin
          d_q  <= rs_mag;
          work <= {32'd0, rt_mag};
        end
`ifdef MDU_DIV_EN
        is_div <= op_div;
        neg_r  <= rs_neg;
        dz     <= (rt1 == 32'd0);
        a_q    <= rs1;
`endif
      end else if (state == RUN) begin
        cnt  <= cnt + 5'd1;
        work <= work_nx;
        if (cnt == 5'd31) begin
`ifdef MDU_DIV_EN
          if (is_div) begin
            // Divide by zero bypasses sign fix-up: all-ones quotient, raw dividend.
            if (dz) begin
              lo <= 32'hFFFF_FFFF;
              hi <= a_q;
            end else begin
              lo <= quo;
              hi <= rem;
            end
          end else begin
            {hi, lo} <= prod;
          end
`else
          {hi, lo} <= prod;
`endif
        end
      end else if (start) begin
        if (op == 3'b100) hi <= rs1;
        if (op == 3'b101) lo <= rs1;
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - randomized self-checking bench for mdu against an arithmetic model

module tb_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1, rt1;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  mdu dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .rs1   (rs1),
    .rt1   (rt1),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit iter_op(input logic [2:0] o);
`ifdef MDU_DIV_EN
    return (o[2] == 1'b0);
`else
    return (o[2:1] == 2'b00);
`endif
  endfunction

  // Architectural effect of an accepted operation on HI/LO.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = 64'(sa * sb); hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; hi_m = p[63:32]; lo_m = p[31:0]; end
`ifdef MDU_DIV_EN
      3'd2: begin
        if (b == 32'd0) begin lo_m = 32'hFFFF_FFFF; hi_m = a; end
        else begin lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); end
      end
      3'd3: begin
        if (b == 32'd0) begin lo_m = 32'hFFFF_FFFF; hi_m = a; end
        else begin lo_m = a / b; hi_m = a % b; end
      end
`endif
      3'd4: hi_m = a;
      3'd5: lo_m = a;
      default: ;
    endcase
  endtask

  // Called at a negedge; returns at the negedge where the result is visible.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj_at = -1, input logic [2:0] inj_op = 3'd4,
                        input logic [31:0] inj_val = 32'h1234);
    logic [31:0] hi0, lo0;
    int          cyc;
    bit          stable;
    hi0 = hi_m;
    lo0 = lo_m;
    start = 1'b1; op = o; rs1 = a; rt1 = b;
    @(negedge clk);
    start = 1'b0;
    model(o, a, b);
    if (iter_op(o)) begin
      cyc = 0;
      stable = 1'b1;
      while (busy === 1'b1 && cyc < 100) begin
        if (hi !== hi0 || lo !== lo0 || done !== 1'b0) stable = 1'b0;
        if (cyc == inj_at) begin
          start = 1'b1; op = inj_op; rs1 = inj_val; rt1 = inj_val;
        end else begin
          start = 1'b0;
        end
        cyc++;
        @(negedge clk);
      end
      start = 1'b0;
      check($sformatf("busy_cycles op%0d", o), 64'(cyc), 64'd32);
      check($sformatf("hold_while_busy op%0d", o), {63'd0, stable}, 64'd1);
      check($sformatf("done_pulse op%0d", o), {63'd0, done}, 64'd1);
      check($sformatf("hi op%0d %h %h", o, a, b), {32'd0, hi}, {32'd0, hi_m});
      check($sformatf("lo op%0d %h %h", o, a, b), {32'd0, lo}, {32'd0, lo_m});
    end else begin
      check($sformatf("no_busy op%0d", o), {63'd0, busy}, 64'd0);
      check($sformatf("no_done op%0d", o), {63'd0, done}, 64'd0);
      check($sformatf("hi op%0d %h", o, a), {32'd0, hi}, {32'd0, hi_m});
      check($sformatf("lo op%0d %h", o, a), {32'd0, lo}, {32'd0, lo_m});
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; op = 3'd0; rs1 = 32'd0; rt1 = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);

    // First start right after reset release, then directed cases.
    rst = 1'b0;
    run_op(3'd1, 32'hFFFF_FFFF, 32'h2);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd3, 32'd5, 32'd0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd0);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000);

    // Requests while busy are ignored; back-to-back MTHI after done is taken.
    run_op(3'd1, 32'd100, 32'd200, 5, 3'd4, 32'h1234);
    run_op(3'd4, 32'h1234, 32'd0);
    run_op(3'd0, 32'd9, 32'd9, 3, 3'd1, 32'h55);
    run_op(3'd0, 32'd11, 32'd13, 7, 3'd5, 32'h77);
    run_op(3'd6, 32'hDEAD_BEEF, 32'd1);
    run_op(3'd7, 32'hCAFE_F00D, 32'd2);
    run_op(3'd5, 32'h0BAD_F00D, 32'd0);

    // Reset in the middle of a multiply.
    start = 1'b1; op = 3'd1; rs1 = 32'hDEAD; rt1 = 32'hBEEF;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    hi_m = 32'd0;
    lo_m = 32'd0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) seen = 1'b1;
    end
    check("abort_quiet", {63'd0, seen}, 64'd0);
    run_op(3'd1, 32'd3, 32'd4);

    // Randomized mix, sometimes back-to-back, sometimes with an idle gap.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_op(o, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
